// File: rtl/systolic_tile_engine_pkg.sv
// Shared state encoding, lane types and flush-length constants for the systolic tile engine.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package systolic_pkg;

  localparam int SE_N          = 8;
  localparam int SE_DATA_WIDTH = 16;
  localparam int SE_ACC_WIDTH  = 40;

  // Zero-injection steps needed for the last k-slice to reach PE(N-1,N-1).
  localparam int FLUSH_STEPS = 2 * SE_N - 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_DRAIN = 2'd3
  } se_state_t;

  typedef logic [SE_N-1:0][SE_DATA_WIDTH-1:0] operand_vec_t;
  typedef logic [SE_N-1:0][SE_ACC_WIDTH-1:0]  acc_vec_t;

  // Flush length for an arbitrary array dimension.
  function automatic int flush_steps(input int n);
    return 2 * n - 2;
  endfunction

endpackage

// File: rtl/systolic_tile_engine_if.sv
// Control, operand-stream and result-stream bundle between the engine and its neighbours.
// Latency: none (wiring only).
// Backpressure: in_valid/in_ready for operand beats, out_valid/out_ready for result rows.
interface systolic_tile_engine_if #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int K_WIDTH    = 12
);
  logic                    start;
  logic [K_WIDTH-1:0]      k_len;
  logic                    accumulate;
  logic                    in_valid;
  logic                    in_ready;
  logic [N*DATA_WIDTH-1:0] a_col;
  logic [N*DATA_WIDTH-1:0] b_row;
  logic                    out_valid;
  logic                    out_ready;
  logic [N*ACC_WIDTH-1:0]  out_row;
  logic                    out_last;
  logic                    busy;
  logic                    done;

  modport master (
    output start, k_len, accumulate, in_valid, a_col, b_row, out_ready,
    input  in_ready, out_valid, out_row, out_last, busy, done
  );

  modport slave (
    input  start, k_len, accumulate, in_valid, a_col, b_row, out_ready,
    output in_ready, out_valid, out_row, out_last, busy, done
  );
endinterface

// File: rtl/systolic_tile_engine_skew_line.sv
// Step-enabled delay line that skews one operand lane by DEPTH array steps.
// Latency: DEPTH steps (DEPTH=0 is a combinational passthrough).
// Backpressure: holds contents whenever i_en is low.
module skew_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_dat,
  output logic [WIDTH-1:0] o_dat
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign o_dat = i_dat;
    end else begin : g_sr
      logic [DEPTH-1:0][WIDTH-1:0] r_sr;

      // Shift one stage per array step; clear wipes stale data at tile start.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          r_sr <= '0;
        end else if (i_clr) begin
          r_sr <= '0;
        end else if (i_en) begin
          r_sr[0] <= i_dat;
          for (int k = 1; k < DEPTH; k++) begin
            r_sr[k] <= r_sr[k-1];
          end
        end
      end

      assign o_dat = r_sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/systolic_tile_engine.sv
// N x N output-stationary systolic engine: C = A*B or C += A*B, K chosen per tile.
// Latency: last operand beat -> first result row in 2N-1 cycles; one row per accepted beat after that.
// Backpressure: bubbles on in_valid freeze the array; out_ready low holds the current row stable.
module systolic_tile_engine
  import systolic_pkg::*;
#(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int K_WIDTH    = 12
) (
  input  logic                   clock,
  input  logic                   reset_n,
  systolic_tile_engine_if.slave  bus
);

  localparam int RW        = $clog2(N);
  localparam int FLUSH_LEN = flush_steps(N);

  se_state_t          r_state;
  se_state_t          w_state_nxt;
  logic [K_WIDTH-1:0] r_k_len;
  logic [K_WIDTH-1:0] r_cnt;
  logic [RW-1:0]      r_row;
  logic               r_done;

  logic w_start_acc;
  logic w_beat;
  logic w_step;
  logic w_load_last;
  logic w_flush_last;
  logic w_row_acc;
  logic w_row_last;

  logic signed [DATA_WIDTH-1:0] w_a_lane [N];
  logic signed [DATA_WIDTH-1:0] w_b_lane [N];
  logic signed [DATA_WIDTH-1:0] w_a_sk   [N];
  logic signed [DATA_WIDTH-1:0] w_b_sk   [N];
  logic signed [DATA_WIDTH-1:0] w_a_pass [N][N-1];
  logic signed [DATA_WIDTH-1:0] w_b_pass [N-1][N];
  logic signed [ACC_WIDTH-1:0]  w_acc    [N][N];

  assign w_start_acc  = (r_state == S_IDLE) && bus.start;
  assign w_beat       = (r_state == S_LOAD) && bus.in_valid;
  assign w_step       = w_beat || (r_state == S_FLUSH);
  assign w_load_last  = w_beat && (r_cnt == r_k_len - K_WIDTH'(1));
  assign w_flush_last = (r_state == S_FLUSH) && (r_cnt == K_WIDTH'(FLUSH_LEN - 1));
  assign w_row_acc    = (r_state == S_DRAIN) && bus.out_ready;
  assign w_row_last   = (r_row == RW'(N - 1));

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake outputs; all outputs depend only on registered state.
  always_comb begin
    w_state_nxt   = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    bus.out_row   = '0;
    bus.busy      = (r_state != S_IDLE);
    bus.done      = r_done;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = (bus.k_len != '0) ? S_LOAD : S_DRAIN;
        end
      end
      S_LOAD: begin
        bus.in_ready = 1'b1;
        if (w_load_last) begin
          w_state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (w_flush_last) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        bus.out_valid = 1'b1;
        bus.out_last  = w_row_last;
        for (int c = 0; c < N; c++) begin
          bus.out_row[c*ACC_WIDTH +: ACC_WIDTH] = w_acc[r_row][c];
        end
        if (w_row_acc && w_row_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Beat/flush step counter, latched K, drain row index and the done pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_k_len <= '0;
      r_cnt   <= '0;
      r_row   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_row_acc && w_row_last;
      if (w_start_acc) begin
        r_k_len <= bus.k_len;
        r_cnt   <= '0;
        r_row   <= '0;
      end else if (w_load_last || w_flush_last) begin
        r_cnt <= '0;
      end else if (w_step) begin
        r_cnt <= r_cnt + K_WIDTH'(1);
      end
      if (w_row_acc) begin
        r_row <= w_row_last ? '0 : r_row + RW'(1);
      end
    end
  end

  // Operand lanes: live data while loading, zeros while flushing.
  generate
    for (genvar i = 0; i < N; i++) begin : g_skew
      assign w_a_lane[i] = (r_state == S_LOAD) ? bus.a_col[i*DATA_WIDTH +: DATA_WIDTH] : '0;
      assign w_b_lane[i] = (r_state == S_LOAD) ? bus.b_row[i*DATA_WIDTH +: DATA_WIDTH] : '0;
      if (i == 0) begin : g_l0
        assign w_a_sk[0] = w_a_lane[0];
        assign w_b_sk[0] = w_b_lane[0];
      end else begin : g_ln
        skew_line #(.DEPTH(i), .WIDTH(DATA_WIDTH)) u_skew_a (
          .clock   (clock),
          .reset_n (reset_n),
          .i_en    (w_step),
          .i_clr   (w_start_acc),
          .i_dat   (w_a_lane[i]),
          .o_dat   (w_a_sk[i])
        );
        skew_line #(.DEPTH(i), .WIDTH(DATA_WIDTH)) u_skew_b (
          .clock   (clock),
          .reset_n (reset_n),
          .i_en    (w_step),
          .i_clr   (w_start_acc),
          .i_dat   (w_b_lane[i]),
          .o_dat   (w_b_sk[i])
        );
      end
    end
  endgenerate

  // PE grid: A flows right, B flows down, each PE keeps its own C element.
  generate
    for (genvar r = 0; r < N; r++) begin : g_row
      for (genvar c = 0; c < N; c++) begin : g_pe
        logic signed [DATA_WIDTH-1:0]   w_a;
        logic signed [DATA_WIDTH-1:0]   w_b;
        logic signed [2*DATA_WIDTH-1:0] w_prod;
        logic signed [ACC_WIDTH-1:0]    r_acc;

        if (c == 0) begin : g_a_edge
          assign w_a = w_a_sk[r];
        end else begin : g_a_nbr
          assign w_a = w_a_pass[r][c-1];
        end
        if (r == 0) begin : g_b_edge
          assign w_b = w_b_sk[c];
        end else begin : g_b_nbr
          assign w_b = w_b_pass[r-1][c];
        end

        // Full-width signed product; the widening casts sign-extend.
        assign w_prod = (2*DATA_WIDTH)'(w_a) * (2*DATA_WIDTH)'(w_b);
        assign w_acc[r][c] = r_acc;

        // Accumulate once per step; cleared at start unless the tile accumulates.
        always_ff @(posedge clock or negedge reset_n) begin
          if (!reset_n) begin
            r_acc <= '0;
          end else if (w_start_acc && !bus.accumulate) begin
            r_acc <= '0;
          end else if (w_step) begin
            r_acc <= r_acc + ACC_WIDTH'(w_prod);
          end
        end

        if (c < N - 1) begin : g_a_reg
          logic signed [DATA_WIDTH-1:0] r_a;
          // Forward A to the right neighbour on each step.
          always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
              r_a <= '0;
            end else if (w_start_acc) begin
              r_a <= '0;
            end else if (w_step) begin
              r_a <= w_a;
            end
          end
          assign w_a_pass[r][c] = r_a;
        end

        if (r < N - 1) begin : g_b_reg
          logic signed [DATA_WIDTH-1:0] r_b;
          // Forward B to the PE below on each step.
          always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
              r_b <= '0;
            end else if (w_start_acc) begin
              r_b <= '0;
            end else if (w_step) begin
              r_b <= w_b;
            end
          end
          assign w_b_pass[r][c] = r_b;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_systolic_tile_engine.sv
// Directed self-checking bench for systolic_tile_engine at N=4, 16-bit operands, 32-bit accumulators.
// Latency: n/a (testbench).
// Backpressure: exercises input bubbles and output stalls.
module tb_systolic_tile_engine;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int KW = 12;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  systolic_tile_engine_if #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .K_WIDTH(KW)) bus ();

  systolic_tile_engine #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .K_WIDTH(KW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  int mA [N][8];
  int mB [8][N];

  logic [N*AW-1:0] got_row [N];
  logic [N-1:0]    got_last;
  int drain_to, stall_changes, ir_high;
  logic done_seen, busy_after, done_after;

  function automatic logic [N*DW-1:0] pack_a(input int k);
    logic [N*DW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(mA[i][k]);
    return v;
  endfunction

  function automatic logic [N*DW-1:0] pack_b(input int k);
    logic [N*DW-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++) v[j*DW +: DW] = DW'(mB[k][j]);
    return v;
  endfunction

  function automatic logic [N*AW-1:0] rep_row(input logic [AW-1:0] e);
    logic [N*AW-1:0] v;
    for (int j = 0; j < N; j++) v[j*AW +: AW] = e;
    return v;
  endfunction

  function automatic logic [N*AW-1:0] ident_row(input int r);
    logic [N*AW-1:0] v;
    for (int j = 0; j < N; j++) v[j*AW +: AW] = AW'(4*r + j + 1);
    return v;
  endfunction

  task automatic set_identity();
    for (int i = 0; i < N; i++) for (int k = 0; k < 8; k++) mA[i][k] = (i == k) ? 1 : 0;
    for (int k = 0; k < 8; k++) for (int j = 0; j < N; j++) mB[k][j] = 4*k + j + 1;
  endtask

  task automatic set_const(input int a, input int b);
    for (int i = 0; i < N; i++) for (int k = 0; k < 8; k++) mA[i][k] = a;
    for (int k = 0; k < 8; k++) for (int j = 0; j < N; j++) mB[k][j] = b;
  endtask

  // Called at a falling edge; returns one falling edge later (cycle t+1).
  task automatic do_start(input int k, input logic acc);
    bus.start      = 1'b1;
    bus.k_len      = KW'(k);
    bus.accumulate = acc;
    @(negedge clock);
    bus.start      = 1'b0;
    bus.k_len      = '0;
    bus.accumulate = 1'b0;
  endtask

  task automatic send_beats(input int k, input bit gap, output bit to);
    int  i   = 0;
    int  cyc = 0;
    bit  hs;
    while (i < k && cyc < 200) begin
      if (gap && (cyc % 2 == 1)) begin
        bus.in_valid = 1'b0;
        bus.a_col    = {$urandom(), $urandom()};
        bus.b_row    = {$urandom(), $urandom()};
      end else begin
        bus.in_valid = 1'b1;
        bus.a_col    = pack_a(i);
        bus.b_row    = pack_b(i);
      end
      hs = bus.in_valid && bus.in_ready;
      @(negedge clock);
      cyc++;
      if (hs) i++;
    end
    bus.in_valid = 1'b0;
    bus.a_col    = '0;
    bus.b_row    = '0;
    to = (i < k);
  endtask

  // Counts cycles from the cycle after the last beat until out_valid.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      if (bus.in_ready) ir_high++;
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic drain_rows(input int stall, input bit poke_start);
    int cnt;
    logic [N*AW-1:0] hold_row;
    logic hold_last;
    drain_to = 0;
    stall_changes = 0;
    for (int r = 0; r < N; r++) begin
      cnt = 0;
      while (!bus.out_valid && cnt < 100) begin
        @(negedge clock);
        cnt++;
      end
      if (cnt >= 100) begin
        drain_to = 1;
        bus.out_ready = 1'b0;
        bus.start = 1'b0;
        return;
      end
      if (poke_start) begin
        bus.start = (r < N - 1);
        bus.k_len = '0;
        bus.accumulate = 1'b0;
      end
      if (bus.in_ready) ir_high++;
      hold_row  = bus.out_row;
      hold_last = bus.out_last;
      for (int s = 0; s < stall; s++) begin
        bus.out_ready = 1'b0;
        @(negedge clock);
        if (bus.out_row !== hold_row || bus.out_last !== hold_last || bus.out_valid !== 1'b1)
          stall_changes++;
      end
      bus.out_ready = 1'b1;
      got_row[r]  = bus.out_row;
      got_last[r] = bus.out_last;
      @(negedge clock);
      bus.out_ready = 1'b0;
    end
    bus.start  = 1'b0;
    done_seen  = bus.done;
    busy_after = bus.busy;
    @(negedge clock);
    done_after = bus.done;
  endtask

  task automatic test_reset();
    @(negedge clock);
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_last !== 1'b0) begin failures++; $display("FAIL rst_out_last got=%b exp=0", bus.out_last); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", bus.done); end
    checks++; if (bus.out_row !== '0) begin failures++; $display("FAIL rst_out_row got=%h exp=0", bus.out_row); end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_identity();
    bit to;
    int lat;
    set_identity();
    ir_high = 0;
    do_start(4, 1'b0);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL id_busy_t1 got=%b exp=1", bus.busy); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL id_in_ready_t1 got=%b exp=1", bus.in_ready); end
    send_beats(4, 1'b0, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL id_send_timeout got=%b exp=0", to); end
    wait_valid(lat);
    checks++; if (lat != 2*N - 1) begin failures++; $display("FAIL id_first_valid_lat got=%0d exp=%0d", lat, 2*N-1); end
    drain_rows(0, 1'b0);
    checks++; if (drain_to != 0) begin failures++; $display("FAIL id_drain_timeout got=%0d exp=0", drain_to); end
    for (int r = 0; r < N; r++) begin
      checks++;
      if (got_row[r] !== ident_row(r)) begin failures++; $display("FAIL id_row%0d got=%h exp=%h", r, got_row[r], ident_row(r)); end
    end
    checks++; if (got_last !== 4'b1000) begin failures++; $display("FAIL id_last got=%b exp=1000", got_last); end
    checks++; if (done_seen !== 1'b1) begin failures++; $display("FAIL id_done got=%b exp=1", done_seen); end
    checks++; if (busy_after !== 1'b0) begin failures++; $display("FAIL id_busy_done got=%b exp=0", busy_after); end
    checks++; if (done_after !== 1'b0) begin failures++; $display("FAIL id_done_pulse got=%b exp=0", done_after); end
    checks++; if (ir_high != 0) begin failures++; $display("FAIL id_in_ready_outside_load got=%0d exp=0", ir_high); end
  endtask

  task automatic test_stall();
    bit to;
    int lat;
    set_identity();
    ir_high = 0;
    do_start(4, 1'b0);
    send_beats(4, 1'b1, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL st_send_timeout got=%b exp=0", to); end
    wait_valid(lat);
    checks++; if (lat != 2*N - 1) begin failures++; $display("FAIL st_first_valid_lat got=%0d exp=%0d", lat, 2*N-1); end
    drain_rows(3, 1'b0);
    checks++; if (drain_to != 0) begin failures++; $display("FAIL st_drain_timeout got=%0d exp=0", drain_to); end
    for (int r = 0; r < N; r++) begin
      checks++;
      if (got_row[r] !== ident_row(r)) begin failures++; $display("FAIL st_row%0d got=%h exp=%h", r, got_row[r], ident_row(r)); end
    end
    checks++; if (stall_changes != 0) begin failures++; $display("FAIL st_row_stable got=%0d exp=0", stall_changes); end
    checks++; if (ir_high != 0) begin failures++; $display("FAIL st_in_ready_outside_load got=%0d exp=0", ir_high); end
    checks++; if (got_last !== 4'b1000) begin failures++; $display("FAIL st_last got=%b exp=1000", got_last); end
    checks++; if (done_seen !== 1'b1) begin failures++; $display("FAIL st_done got=%b exp=1", done_seen); end
  endtask

  task automatic test_accumulate();
    bit to;
    int lat;
    set_const(2, 3);
    for (int pass = 0; pass < 2; pass++) begin
      do_start(5, (pass == 1));
      send_beats(5, 1'b0, to);
      wait_valid(lat);
      drain_rows(0, 1'b0);
      checks++; if (drain_to != 0) begin failures++; $display("FAIL acc%0d_drain_timeout got=%0d exp=0", pass, drain_to); end
      for (int r = 0; r < N; r++) begin
        checks++;
        if (got_row[r] !== rep_row(AW'(30 * (pass + 1))))
          begin failures++; $display("FAIL acc%0d_row%0d got=%h exp=%h", pass, r, got_row[r], rep_row(AW'(30 * (pass + 1)))); end
      end
    end
  endtask

  task automatic test_signed_wrap();
    bit to;
    int lat;
    set_const(-32768, -32768);
    do_start(2, 1'b0);
    send_beats(2, 1'b0, to);
    wait_valid(lat);
    drain_rows(0, 1'b0);
    checks++; if (drain_to != 0) begin failures++; $display("FAIL wrap_drain_timeout got=%0d exp=0", drain_to); end
    for (int r = 0; r < N; r++) begin
      checks++;
      if (got_row[r] !== rep_row(32'h8000_0000)) begin failures++; $display("FAIL wrap_row%0d got=%h exp=%h", r, got_row[r], rep_row(32'h8000_0000)); end
    end
  endtask

  task automatic test_zero_k();
    // Accumulate=1 with K=0 reads back the held results of the previous tile.
    do_start(0, 1'b1);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL zk_hold_valid_t1 got=%b exp=1", bus.out_valid); end
    drain_rows(0, 1'b0);
    checks++; if (got_row[2] !== rep_row(32'h8000_0000)) begin failures++; $display("FAIL zk_hold_row2 got=%h exp=%h", got_row[2], rep_row(32'h8000_0000)); end
    do_start(0, 1'b0);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL zk_valid_t1 got=%b exp=1", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL zk_in_ready got=%b exp=0", bus.in_ready); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL zk_busy got=%b exp=1", bus.busy); end
    drain_rows(0, 1'b0);
    checks++; if (drain_to != 0) begin failures++; $display("FAIL zk_drain_timeout got=%0d exp=0", drain_to); end
    for (int r = 0; r < N; r++) begin
      checks++;
      if (got_row[r] !== '0) begin failures++; $display("FAIL zk_row%0d got=%h exp=0", r, got_row[r]); end
    end
    checks++; if (got_last !== 4'b1000) begin failures++; $display("FAIL zk_last got=%b exp=1000", got_last); end
    checks++; if (done_seen !== 1'b1) begin failures++; $display("FAIL zk_done got=%b exp=1", done_seen); end
  endtask

  task automatic test_abort();
    bit to;
    int lat;
    set_identity();
    do_start(4, 1'b0);
    send_beats(2, 1'b0, to);
    reset_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL ab_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL ab_in_ready got=%b exp=0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.done !== 1'b0)
      begin failures++; $display("FAIL ab_outputs got=%b%b%b exp=000", bus.out_valid, bus.out_last, bus.done); end
    checks++; if (bus.out_row !== '0) begin failures++; $display("FAIL ab_out_row got=%h exp=0", bus.out_row); end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    // Accumulate=1 proves the reset wiped the accumulators.
    do_start(4, 1'b1);
    send_beats(4, 1'b0, to);
    wait_valid(lat);
    drain_rows(0, 1'b1);
    checks++; if (drain_to != 0) begin failures++; $display("FAIL ab_drain_timeout got=%0d exp=0", drain_to); end
    for (int r = 0; r < N; r++) begin
      checks++;
      if (got_row[r] !== ident_row(r)) begin failures++; $display("FAIL ab_row%0d got=%h exp=%h", r, got_row[r], ident_row(r)); end
    end
    checks++; if (done_seen !== 1'b1) begin failures++; $display("FAIL ab_done got=%b exp=1", done_seen); end
    checks++; if (done_after !== 1'b0 || bus.busy !== 1'b0)
      begin failures++; $display("FAIL ab_idle_after got=%b%b exp=00", done_after, bus.busy); end
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.k_len      = '0;
    bus.accumulate = 1'b0;
    bus.in_valid   = 1'b0;
    bus.a_col      = '0;
    bus.b_row      = '0;
    bus.out_ready  = 1'b0;
    test_reset();
    test_identity();
    test_stall();
    test_accumulate();
    test_signed_wrap();
    test_zero_k();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
